// File: rtl/issue_sched_if.sv
// Dispatch, CDB wakeup and issue signals for the issue scheduler.
// The master modport drives dispatch/wakeup and accepts issue; the slave modport is the scheduler side.
interface issue_sched_if #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6,
  parameter int OPW   = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            disp_valid;
  logic            disp_ready;
  logic [TAGW-1:0] disp_src1_tag;
  logic [TAGW-1:0] disp_src2_tag;
  logic            disp_src1_rdy;
  logic            disp_src2_rdy;
  logic [TAGW-1:0] disp_dst_tag;
  logic [OPW-1:0]  disp_op;
  logic [31:0]     disp_imm;

  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;

  logic            iss_valid;
  logic            iss_ready;
  logic [TAGW-1:0] iss_src1_tag;
  logic [TAGW-1:0] iss_src2_tag;
  logic [TAGW-1:0] iss_dst_tag;
  logic [OPW-1:0]  iss_op;
  logic [31:0]     iss_imm;

  logic [CW-1:0]   occ_count;

  modport master (
    output disp_valid, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_dst_tag, disp_op, disp_imm, cdb_valid, cdb_tag, iss_ready,
    input  disp_ready, iss_valid, iss_src1_tag, iss_src2_tag, iss_dst_tag,
           iss_op, iss_imm, occ_count
  );

  modport slave (
    input  disp_valid, disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_dst_tag, disp_op, disp_imm, cdb_valid, cdb_tag, iss_ready,
    output disp_ready, iss_valid, iss_src1_tag, iss_src2_tag, iss_dst_tag,
           iss_op, iss_imm, occ_count
  );
endinterface

// File: rtl/issue_sched.sv
// Age-ordered reservation station: oldest ready entry is offered combinationally; CDB wakeup takes one cycle.
// Dispatch stalls only when all entries are held; an offered entry stays put while iss_ready is low.
module issue_sched #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6,
  parameter int OPW   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  issue_sched_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy1;
  logic [DEPTH-1:0] rdy2;
  logic [TAGW-1:0]  src1 [DEPTH];
  logic [TAGW-1:0]  src2 [DEPTH];
  logic [TAGW-1:0]  dst  [DEPTH];
  logic [OPW-1:0]   op   [DEPTH];
  logic [31:0]      imm  [DEPTH];
  logic [RW-1:0]    rank [DEPTH];
  logic [CW-1:0]    cnt;

  logic             sel_found;
  logic [RW-1:0]    sel_idx;
  logic [RW-1:0]    sel_rank;
  logic             free_found;
  logic [RW-1:0]    free_idx;
  logic             do_disp;
  logic             do_iss;
  logic [RW-1:0]    new_rank;
  logic             disp_wake1;
  logic             disp_wake2;

  // Ranks of valid entries are unique, so the strict compare yields a single winner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && rdy1[i] && rdy2[i] && (!sel_found || rank[i] < sel_rank)) begin
        sel_found = 1'b1;
        sel_idx   = RW'(i);
        sel_rank  = rank[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RW'(i);
      end
    end
  end

  assign bus.disp_ready   = (cnt < FULL) && !rst && !flush;
  assign do_disp          = bus.disp_valid && bus.disp_ready && free_found;
  assign do_iss           = sel_found && bus.iss_ready;
  // cnt never reaches DEPTH on a dispatch cycle, so its low bits hold the full value.
  assign new_rank         = cnt[RW-1:0] - RW'(do_iss);
  assign disp_wake1       = bus.cdb_valid && (bus.cdb_tag == bus.disp_src1_tag);
  assign disp_wake2       = bus.cdb_valid && (bus.cdb_tag == bus.disp_src2_tag);

  assign bus.iss_valid    = sel_found;
  assign bus.iss_src1_tag = src1[sel_idx];
  assign bus.iss_src2_tag = src2[sel_idx];
  assign bus.iss_dst_tag  = dst[sel_idx];
  assign bus.iss_op       = op[sel_idx];
  assign bus.iss_imm      = imm[sel_idx];
  assign bus.occ_count    = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld  <= '0;
      rdy1 <= '0;
      rdy2 <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) rank[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_disp && free_idx == RW'(i)) begin
          vld[i]  <= 1'b1;
          rdy1[i] <= bus.disp_src1_rdy || disp_wake1;
          rdy2[i] <= bus.disp_src2_rdy || disp_wake2;
          rank[i] <= new_rank;
        end else if (vld[i]) begin
          if (bus.cdb_valid && src1[i] == bus.cdb_tag) rdy1[i] <= 1'b1;
          if (bus.cdb_valid && src2[i] == bus.cdb_tag) rdy2[i] <= 1'b1;
          if (do_iss && sel_idx == RW'(i)) begin
            vld[i] <= 1'b0;
          end else if (do_iss && rank[i] > sel_rank) begin
            rank[i] <= rank[i] - RW'(1);
          end
        end
      end
      case ({do_disp, do_iss})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_disp && !rst && !flush && free_idx == RW'(i)) begin
        src1[i] <= bus.disp_src1_tag;
        src2[i] <= bus.disp_src2_tag;
        dst[i]  <= bus.disp_dst_tag;
        op[i]   <= bus.disp_op;
        imm[i]  <= bus.disp_imm;
      end
    end
  end
endmodule
